// File: rtl/fifo_ctrl_if.sv
// Handshake bundle between producer/consumer and the FIFO pointer controller.
// The master side issues requests; the slave side (fifo_ctrl) returns acceptance and status.
interface fifo_ctrl_if #(
   parameter int ADDR_W = 4
);
   logic              wr;
   logic              rd;
   logic              clr_err;
   logic              fifo_we;
   logic              fifo_rd;
   logic [ADDR_W:0]   wptr;
   logic [ADDR_W:0]   rptr;
   logic [ADDR_W:0]   level;
   logic              fifo_full;
   logic              fifo_empty;
   logic              almost_full;
   logic              almost_empty;
   logic              fifo_overflow;
   logic              fifo_underflow;

   modport master (
      output wr, rd, clr_err,
      input  fifo_we, fifo_rd, wptr, rptr, level, fifo_full, fifo_empty,
             almost_full, almost_empty, fifo_overflow, fifo_underflow
   );

   modport slave (
      input  wr, rd, clr_err,
      output fifo_we, fifo_rd, wptr, rptr, level, fifo_full, fifo_empty,
             almost_full, almost_empty, fifo_overflow, fifo_underflow
   );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/status controller for the audio sample FIFO array (FWFT read side).
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fifo_ctrl #(
   parameter int ADDR_W   = 4,
   parameter int AF_LEVEL = 12,
   parameter int AE_LEVEL = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   fifo_ctrl_if.slave bus
);
   localparam logic [ADDR_W:0] AF_L = (ADDR_W+1)'(AF_LEVEL);
   localparam logic [ADDR_W:0] AE_L = (ADDR_W+1)'(AE_LEVEL);
   localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

   logic [ADDR_W:0] wptr_q, rptr_q, level;
   logic            full, empty, we, re;
   logic            ovf_q, unf_q;

   assign level = wptr_q - rptr_q;
   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                  (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);

   // Strobes are forced low while reset is held so the array is never written mid-reset.
   assign we = bus.wr & ~full  & rst_n;
   assign re = bus.rd & ~empty & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else begin
         if (we) wptr_q <= wptr_q + ONE;
         if (re) rptr_q <= rptr_q + ONE;
         // A new error on the same edge as clr_err keeps the flag set.
         ovf_q <= (bus.wr & full)  | (ovf_q & ~bus.clr_err);
         unf_q <= (bus.rd & empty) | (unf_q & ~bus.clr_err);
      end
   end

   assign bus.fifo_we        = we;
   assign bus.fifo_rd        = re;
   assign bus.wptr           = wptr_q;
   assign bus.rptr           = rptr_q;
   assign bus.level          = level;
   assign bus.fifo_full      = full;
   assign bus.fifo_empty     = empty;
   assign bus.almost_full    = (level >= AF_L);
   assign bus.almost_empty   = (level <= AE_L);
   assign bus.fifo_overflow  = ovf_q;
   assign bus.fifo_underflow = unf_q;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl: stimulus queues the expected cycle view,
// a negedge monitor compares it, and a local array model checks FWFT data order.
module tb_fifo_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [15:0] data_in = '0;
   logic [15:0] mem [16];

   fifo_ctrl_if #(.ADDR_W(4)) bus ();

   fifo_ctrl #(.ADDR_W(4), .AF_LEVEL(12), .AE_LEVEL(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Stand-in for the memory array, driven by the DUT's strobes and pointers.
   always @(posedge clk) if (bus.fifo_we) mem[bus.wptr[3:0]] <= data_in;

   typedef struct {
      bit       we, rdacc, full, empty, af, ae, ovf, unf, chk_data;
      int       wptr, rptr, level;
      bit [15:0] data;
   } exp_t;

   exp_t exp_q[$];
   bit [15:0] ref_q[$];
   int wcnt, rcnt;
   bit m_ovf, m_unf;
   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: one queued expectation per stimulus cycle, compared mid-cycle.
   initial forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("fifo_we",        int'(bus.fifo_we),        int'(e.we));
         chk("fifo_rd",        int'(bus.fifo_rd),        int'(e.rdacc));
         chk("wptr",           int'(bus.wptr),           e.wptr);
         chk("rptr",           int'(bus.rptr),           e.rptr);
         chk("level",          int'(bus.level),          e.level);
         chk("fifo_full",      int'(bus.fifo_full),      int'(e.full));
         chk("fifo_empty",     int'(bus.fifo_empty),     int'(e.empty));
         chk("almost_full",    int'(bus.almost_full),    int'(e.af));
         chk("almost_empty",   int'(bus.almost_empty),   int'(e.ae));
         chk("fifo_overflow",  int'(bus.fifo_overflow),  int'(e.ovf));
         chk("fifo_underflow", int'(bus.fifo_underflow), int'(e.unf));
         if (e.chk_data) chk("rd_data", int'(mem[bus.rptr[3:0]]), int'(e.data));
      end
   end

   task automatic model_reset();
      wcnt = 0; rcnt = 0; m_ovf = 0; m_unf = 0;
      ref_q.delete();
   endtask

   // One request cycle: drive, queue expectation of this cycle, advance model to post-edge.
   task automatic step(input bit w, input bit r, input bit c, input bit [15:0] d);
      exp_t e;
      int lvl;
      @(posedge clk); #1;
      bus.wr = w; bus.rd = r; bus.clr_err = c; data_in = d;
      lvl = wcnt - rcnt;
      e.we = w && (lvl < 16);
      e.rdacc = r && (lvl > 0);
      e.wptr = wcnt % 32; e.rptr = rcnt % 32; e.level = lvl;
      e.full = (lvl == 16); e.empty = (lvl == 0);
      e.af = (lvl >= 12); e.ae = (lvl <= 4);
      e.ovf = m_ovf; e.unf = m_unf;
      e.chk_data = (lvl > 0);
      e.data = (lvl > 0) ? ref_q[0] : 16'h0;
      exp_q.push_back(e);
      if (e.we) begin ref_q.push_back(d); wcnt++; end
      if (e.rdacc) begin void'(ref_q.pop_front()); rcnt++; end
      m_ovf = (w && lvl == 16) || (m_ovf && !c);
      m_unf = (r && lvl == 0)  || (m_unf && !c);
   endtask

   task automatic idle_sample();
      @(posedge clk); #1;
      bus.wr = 0; bus.rd = 0; bus.clr_err = 0;
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      bus.wr = 1; bus.rd = 1; bus.clr_err = 0;
      #2;
      chk("rst_level",  int'(bus.level), 0);
      chk("rst_empty",  int'(bus.fifo_empty), 1);
      chk("rst_full",   int'(bus.fifo_full), 0);
      chk("rst_ae",     int'(bus.almost_empty), 1);
      chk("rst_af",     int'(bus.almost_full), 0);
      chk("rst_we",     int'(bus.fifo_we), 0);
      chk("rst_rd",     int'(bus.fifo_rd), 0);
      chk("rst_ovf",    int'(bus.fifo_overflow), 0);
      chk("rst_unf",    int'(bus.fifo_underflow), 0);
      bus.wr = 0; bus.rd = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;

      // Fill to full
      for (int i = 0; i < 16; i++) step(1, 0, 0, 16'hA000 + 16'(i));
      idle_sample();
      chk("full_wptr",  int'(bus.wptr), 16);
      chk("full_flag",  int'(bus.fifo_full), 1);
      chk("full_level", int'(bus.level), 16);

      // Overflow then clear
      step(1, 0, 0, 16'hDEAD);
      step(0, 0, 1, 16'h0);
      step(0, 0, 0, 16'h0);

      // Drain, then underflow
      for (int i = 0; i < 16; i++) step(0, 1, 0, 16'h0);
      idle_sample();
      chk("empty_rptr", int'(bus.rptr), 16);
      step(0, 1, 0, 16'h0);
      step(0, 0, 1, 16'h0);

      // Steady-state wr&rd at level 5 across pointer wrap
      for (int i = 0; i < 5; i++) step(1, 0, 0, 16'h5000 + 16'(i));
      for (int i = 0; i < 40; i++) step(1, 1, 0, 16'h6000 + 16'(i));
      idle_sample();
      chk("wrap_level", int'(bus.level), 5);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 16'h0);
      step(1, 1, 0, 16'h7777);      // empty: write taken, read rejected
      step(0, 0, 0, 16'h0);
      step(0, 1, 0, 16'h0);
      step(0, 0, 1, 16'h0);

      // Underflow and clr_err on the same edge
      step(0, 1, 1, 16'h0);
      step(0, 0, 0, 16'h0);
      idle_sample();
      chk("same_edge_unf", int'(bus.fifo_underflow), 1);

      // Async reset mid-burst at level 9
      for (int i = 0; i < 9; i++) step(1, 0, 0, 16'h9000 + 16'(i));
      @(posedge clk); #1;
      bus.wr = 1; bus.rd = 0; bus.clr_err = 0;
      chk("pre_rst_level", int'(bus.level), 9);
      #2 rst_n = 0;
      #1;
      chk("mid_rst_wptr",  int'(bus.wptr), 0);
      chk("mid_rst_rptr",  int'(bus.rptr), 0);
      chk("mid_rst_level", int'(bus.level), 0);
      chk("mid_rst_empty", int'(bus.fifo_empty), 1);
      chk("mid_rst_ae",    int'(bus.almost_empty), 1);
      chk("mid_rst_unf",   int'(bus.fifo_underflow), 0);
      chk("mid_rst_we",    int'(bus.fifo_we), 0);
      @(posedge clk); #1;
      bus.wr = 0;
      rst_n = 1;
      model_reset();
      step(1, 0, 0, 16'hBEEF);
      step(0, 1, 0, 16'h0);
      step(0, 0, 0, 16'h0);

      idle_sample();
      @(posedge clk); #1;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
